// File: rtl/hmmm_datapath.sv
// 8-bit HMMM-subset datapath: PC, instruction/write-back staging, 8x8 register file and add/sub ALU.
// Optional build macro HMMM_R0_ZERO_EN hardwires register 0 to zero.
module hmmm_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             PCEnable,
    input  logic             AdrSrc,
    input  logic             InstrSrc,
    input  logic             RA1Src,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic             TwoRegs,
    input  logic             ALUSub,
    input  logic             RegWLoadSrc,
    input  logic [1:0]       PCSrc,
    input  logic [1:0]       RegWriteSrc,
    input  logic [2:0]       instr1,
    input  logic [WIDTH-1:0] MemData2,
    output logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] Adr,
    output logic             negative,
    output logic             zero
);

    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] instr_temp2_r;
    logic [WIDTH-1:0] instr2_s;
    logic [WIDTH-1:0] wd3_stage_r;
    logic [WIDTH-1:0] wd3_temp_s;
    logic [WIDTH-1:0] wd3_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic [WIDTH-1:0] src_a_s;
    logic [WIDTH-1:0] src_b_s;
    logic [WIDTH-1:0] result_s;
    logic [2:0]       ra1_s;
    logic [2:0]       ra2_s;
    logic [2:0]       wa3_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] rf_r [8];
    logic             unused_mem_write_s;

    // The store-cycle strobe only steers the bus driver in the top level.
    assign unused_mem_write_s = MemWrite;

    assign instr2_s = InstrSrc ? MemData2 : instr_temp2_r;
    assign ra1_s    = RA1Src ? instr1 : instr2_s[7:5];
    assign ra2_s    = instr2_s[4:2];
    assign wa3_s    = instr1;

`ifdef HMMM_R0_ZERO_EN
    assign rd1_s   = (ra1_s == 3'd0) ? {WIDTH{1'b0}} : rf_r[ra1_s];
    assign rd2_s   = (ra2_s == 3'd0) ? {WIDTH{1'b0}} : rf_r[ra2_s];
    assign wr_en_s = RegWrite && (wa3_s != 3'd0);
`else
    assign rd1_s   = rf_r[ra1_s];
    assign rd2_s   = rf_r[ra2_s];
    assign wr_en_s = RegWrite;
`endif

    // Subtract is two's complement: inverted operand plus carry-in.
    assign src_a_s  = TwoRegs ? rd1_s : {WIDTH{1'b0}};
    assign src_b_s  = ALUSub ? ~rd2_s : rd2_s;
    assign result_s = src_a_s + src_b_s + {{(WIDTH-1){1'b0}}, ALUSub};

    assign wd3_s     = RegWLoadSrc ? wd3_temp_s : wd3_stage_r;
    assign Adr       = AdrSrc ? rd2_s : PC;
    assign WriteData = rd1_s;
    assign negative  = rd1_s[WIDTH-1];
    assign zero      = ~|rd1_s;

    // Next-PC and write-back source selection.
    always_comb begin
        pc_next_s  = PC + {{(WIDTH-1){1'b0}}, 1'b1};
        wd3_temp_s = result_s;
        case (PCSrc)
            2'b00:   pc_next_s = PC + {{(WIDTH-1){1'b0}}, 1'b1};
            2'b01:   pc_next_s = instr2_s;
            default: pc_next_s = rd1_s;
        endcase
        case (RegWriteSrc)
            2'b00:   wd3_temp_s = instr2_s;
            2'b01:   wd3_temp_s = MemData2;
            default: wd3_temp_s = result_s;
        endcase
    end

    // PC and the two per-cycle staging registers.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            PC            <= {WIDTH{1'b0}};
            instr_temp2_r <= {WIDTH{1'b0}};
            wd3_stage_r   <= {WIDTH{1'b0}};
        end else begin
            if (PCEnable) begin
                PC <= pc_next_s;
            end else begin
                PC <= PC;
            end
            instr_temp2_r <= MemData2;
            wd3_stage_r   <= wd3_temp_s;
        end
    end

    // Register file write port; reads above see the old value until the edge.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                rf_r[wa3_s] <= wd3_s;
            end else begin
                rf_r[wa3_s] <= rf_r[wa3_s];
            end
        end
    end

endmodule

// File: tb/tb_hmmm_datapath.sv
// Randomised and directed bench for hmmm_datapath against an arithmetic reference model.
module tb_hmmm_datapath;

    logic       clk1 = 1'b0;
    logic       reset;
    logic       PCEnable, AdrSrc, InstrSrc, RA1Src, RegWrite, MemWrite;
    logic       TwoRegs, ALUSub, RegWLoadSrc;
    logic [1:0] PCSrc, RegWriteSrc;
    logic [2:0] instr1;
    logic [7:0] MemData2;
    logic [7:0] WriteData, Adr;
    logic       negative, zero;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_regs [8];
    logic [7:0] m_pc, m_itemp, m_stage;
    // reference model combinational view for the current cycle
    logic [7:0] e_instr2, e_rd1, e_rd2, e_res, e_temp, e_wd3;
    logic [2:0] e_ra1, e_ra2;

    hmmm_datapath #(.WIDTH(8)) dut (
        .clk1(clk1), .reset(reset), .PCEnable(PCEnable), .AdrSrc(AdrSrc),
        .InstrSrc(InstrSrc), .RA1Src(RA1Src), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .TwoRegs(TwoRegs), .ALUSub(ALUSub), .RegWLoadSrc(RegWLoadSrc), .PCSrc(PCSrc),
        .RegWriteSrc(RegWriteSrc), .instr1(instr1), .MemData2(MemData2),
        .WriteData(WriteData), .Adr(Adr), .negative(negative), .zero(zero)
    );

    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
`ifdef HMMM_R0_ZERO_EN
        if (a == 3'd0) return 8'h00;
`endif
        return m_regs[a];
    endfunction

    task automatic model_comb();
        int a, b, r;
        e_instr2 = InstrSrc ? MemData2 : m_itemp;
        e_ra1    = RA1Src ? instr1 : e_instr2[7:5];
        e_ra2    = e_instr2[4:2];
        e_rd1    = m_read(e_ra1);
        e_rd2    = m_read(e_ra2);
        a = int'(e_rd1);
        b = int'(e_rd2);
        if (TwoRegs && ALUSub)      r = a - b;
        else if (TwoRegs)           r = a + b;
        else if (ALUSub)            r = -b;
        else                        r = b;
        e_res = r[7:0];
        if (RegWriteSrc == 2'b00)      e_temp = e_instr2;
        else if (RegWriteSrc == 2'b01) e_temp = MemData2;
        else                           e_temp = e_res;
        e_wd3 = RegWLoadSrc ? e_temp : m_stage;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pc = 8'h00; m_itemp = 8'h00; m_stage = 8'h00;
    endtask

    task automatic model_edge();
        if (RegWrite) m_regs[instr1] = e_wd3;
        m_stage = e_temp;
        m_itemp = MemData2;
        if (PCEnable) begin
            if (PCSrc == 2'b00)      m_pc = 8'((int'(m_pc) + 1) % 256);
            else if (PCSrc == 2'b01) m_pc = e_instr2;
            else                     m_pc = e_rd1;
        end
    endtask

    task automatic check_outputs();
        model_comb();
        check_val("adr", 32'(Adr), 32'(AdrSrc ? e_rd2 : m_pc));
        check_val("wdata", 32'(WriteData), 32'(e_rd1));
        check_val("negative", 32'(negative), 32'(e_rd1[7]));
        check_val("zero", 32'(zero), 32'(e_rd1 == 8'h00));
    endtask

    // Called just after an edge with inputs already set; returns just after the next edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk1);
        model_edge();
        #1;
        check_val("pc", 32'(dut.PC), 32'(m_pc));
    endtask

    task automatic set_idle();
        PCEnable = 1'b0; AdrSrc = 1'b0; InstrSrc = 1'b0; RA1Src = 1'b0;
        RegWrite = 1'b0; MemWrite = 1'b0; TwoRegs = 1'b0; ALUSub = 1'b0;
        RegWLoadSrc = 1'b1; PCSrc = 2'b00; RegWriteSrc = 2'b00;
        instr1 = 3'd0; MemData2 = 8'h00;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] v);
        set_idle();
        InstrSrc = 1'b1; MemData2 = v; instr1 = a; RegWrite = 1'b1;
        step();
        set_idle();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_val("pc_rst", 32'(dut.PC), 32'h0);
        check_outputs();
        #2 reset = 1'b0;
        @(posedge clk1);
        model_edge();
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk1);
        #1 reset = 1'b0;

        // reset with registers preloaded
        for (int i = 0; i < 8; i++) write_reg(3'(i), 8'(8'h81 + i));
        reset_pulse();
        check_val("pc_after_reset", 32'(dut.PC), 32'h0);
        check_val("adr_after_reset", 32'(Adr), 32'h0);
        for (int i = 0; i < 8; i++) begin
            RA1Src = 1'b1; instr1 = 3'(i);
            #1;
            check_val("reg_cleared", 32'(WriteData), 32'h0);
            check_val("zero_after_reset", 32'(zero), 32'h1);
            check_val("neg_after_reset", 32'(negative), 32'h0);
        end
        set_idle();

        // PC wrap FE -> FF -> 00 -> 01
        PCEnable = 1'b1; PCSrc = 2'b01; InstrSrc = 1'b1; MemData2 = 8'hFE;
        step();
        check_val("pc_load_fe", 32'(dut.PC), 32'hFE);
        set_idle(); PCEnable = 1'b1;
        step(); check_val("pc_wrap_ff", 32'(dut.PC), 32'hFF);
        step(); check_val("pc_wrap_00", 32'(dut.PC), 32'h00);
        step(); check_val("pc_wrap_01", 32'(dut.PC), 32'h01);
        set_idle();

        // immediate write to r3 and read back
        InstrSrc = 1'b1; MemData2 = 8'h2D; instr1 = 3'd3; RegWrite = 1'b1;
        step();
        set_idle(); RA1Src = 1'b1; instr1 = 3'd3;
        #1;
        check_val("r3_imm", 32'(WriteData), 32'h2D);
        check_val("r3_zero", 32'(zero), 32'h0);
        check_val("r3_neg", 32'(negative), 32'h0);

        // subtract 5 - 9 into r4
        write_reg(3'd1, 8'h05);
        write_reg(3'd2, 8'h09);
        InstrSrc = 1'b1; MemData2 = 8'h28; instr1 = 3'd4; TwoRegs = 1'b1; ALUSub = 1'b1;
        RegWriteSrc = 2'b10; RegWrite = 1'b1;
        step();
        set_idle(); RA1Src = 1'b1; instr1 = 3'd4;
        #1;
        check_val("sub_result", 32'(WriteData), 32'hFC);
        check_val("sub_negative", 32'(negative), 32'h1);

        // address from RD2, PC from immediate and from RD1
        write_reg(3'd5, 8'h40);
        write_reg(3'd6, 8'h07);
        InstrSrc = 1'b1; MemData2 = 8'h14; AdrSrc = 1'b1;
        #1;
        check_val("adr_rd2", 32'(Adr), 32'h40);
        set_idle(); InstrSrc = 1'b1; MemData2 = 8'h20; PCSrc = 2'b01; PCEnable = 1'b1;
        step();
        check_val("pc_imm", 32'(dut.PC), 32'h20);
        set_idle(); RA1Src = 1'b1; instr1 = 3'd6; PCSrc = 2'b10; PCEnable = 1'b1;
        step();
        check_val("pc_rd1", 32'(dut.PC), 32'h07);

        // load timing: live vs staged write data
        set_idle(); RegWriteSrc = 2'b01; MemData2 = 8'hA5; instr1 = 3'd7; RegWrite = 1'b1;
        step();
        set_idle(); RA1Src = 1'b1; instr1 = 3'd7;
        #1;
        check_val("load_live", 32'(WriteData), 32'hA5);
        set_idle(); RegWriteSrc = 2'b01; MemData2 = 8'h11;
        step();
        set_idle(); RegWriteSrc = 2'b01; MemData2 = 8'h22; RegWLoadSrc = 1'b0;
        instr1 = 3'd7; RegWrite = 1'b1;
        step();
        set_idle(); RA1Src = 1'b1; instr1 = 3'd7;
        #1;
        check_val("load_staged", 32'(WriteData), 32'h11);
        set_idle();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            PCEnable    = 1'($urandom);
            AdrSrc      = 1'($urandom);
            InstrSrc    = 1'($urandom);
            RA1Src      = 1'($urandom);
            RegWrite    = 1'($urandom);
            MemWrite    = 1'($urandom);
            TwoRegs     = 1'($urandom);
            ALUSub      = 1'($urandom);
            RegWLoadSrc = 1'($urandom);
            PCSrc       = 2'($urandom);
            RegWriteSrc = 2'($urandom);
            instr1      = 3'($urandom);
            MemData2    = 8'($urandom);
            if ($urandom_range(0, 59) == 0) reset_pulse();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
